// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit sequencer
// Purpose: default byte width and the sequencer state encoding.
// Ports:   none (package).
package uart_pkg;

   localparam int WORD_SIZE_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_BRDY  = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/uart_tx_sequencer_rr_arbiter.sv
// rtl/uart_tx_sequencer_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first asserted request scanning upward from ptr, modulo NUM_REQ.
// Ports:   req       in  NUM_REQ  request vector
//          ptr       in  ID_W     index with highest priority this cycle
//          grant     out NUM_REQ  one-hot winner (zero when no request)
//          idx       out ID_W     encoded winner index
//          any_valid out 1        at least one request asserted
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any_valid
);

   always_comb begin
      int          j;
      logic [ID_W-1:0] jj;
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      j         = 0;
      jj        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Rotate the scan start to ptr; wrap past the top requester.
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = ID_W'(j);
         if (!any_valid && req[jj]) begin
            any_valid = 1'b1;
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - round-robin byte sequencer in front of one UART_TX
// Purpose: arbitrate NUM_REQ byte producers, then drive LOAD / BYTE_READY / T_BYTE
//          strobes one cycle each and hold off FRAME_CYCLES cycles per byte.
// Ports:   CLOCK, RESET (sync, active-high)
//          REQ_VALID/REQ_DATA in, REQ_READY out   producer handshake
//          DATA_BUS, LOAD_XMT_DATAREG, BYTE_READY, T_BYTE out   UART_TX controls
//          BUSY out (not IDLE), GRANT_ID out (last accepted requester)
module uart_tx_sequencer
   import uart_pkg::*;
#(
   parameter  int WORD_SIZE    = WORD_SIZE_DEF,
   parameter  int NUM_REQ      = 4,
   parameter  int FRAME_CYCLES = 160,
   localparam int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                         CLOCK,
   input  logic                         RESET,
   input  logic [NUM_REQ-1:0]           REQ_VALID,
   input  logic [NUM_REQ*WORD_SIZE-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]           REQ_READY,
   output logic [WORD_SIZE-1:0]         DATA_BUS,
   output logic                         LOAD_XMT_DATAREG,
   output logic                         BYTE_READY,
   output logic                         T_BYTE,
   output logic                         BUSY,
   output logic [ID_W-1:0]              GRANT_ID
);

   // One extra count value keeps the width non-zero when FRAME_CYCLES is 1.
   localparam int              CNT_W    = $clog2(FRAME_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   seq_state_t       state, state_next;
   logic [ID_W-1:0]  ptr;
   logic [CNT_W-1:0] cnt;
   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]  arb_idx;
   logic             arb_any;
   logic             accept;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (REQ_VALID),
      .ptr       (ptr),
      .grant     (arb_grant),
      .idx       (arb_idx),
      .any_valid (arb_any)
   );

   // Handshake is only offered from IDLE and never while reset is asserted.
   assign accept    = (state == ST_IDLE) && arb_any && !RESET;
   assign REQ_READY = accept ? arb_grant : '0;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         cnt      <= '0;
         DATA_BUS <= '0;
         GRANT_ID <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            DATA_BUS <= REQ_DATA[arb_idx*WORD_SIZE +: WORD_SIZE];
            GRANT_ID <= arb_idx;
            ptr      <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
         end
         // Cleared on the START->WAIT edge so WAIT sees 0..FRAME_CYCLES-1.
         if (state == ST_START)     cnt <= '0;
         else if (state == ST_WAIT) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_next       = state;
      LOAD_XMT_DATAREG = 1'b0;
      BYTE_READY       = 1'b0;
      T_BYTE           = 1'b0;
      BUSY             = (state != ST_IDLE);
      case (state)
         ST_IDLE:  if (arb_any) state_next = ST_LOAD;
         ST_LOAD:  begin LOAD_XMT_DATAREG = 1'b1; state_next = ST_BRDY;  end
         ST_BRDY:  begin BYTE_READY       = 1'b1; state_next = ST_START; end
         ST_START: begin T_BYTE           = 1'b1; state_next = ST_WAIT;  end
         ST_WAIT:  if (cnt == CNT_LAST) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

endmodule
